eth_tx_framer: RTL and testbench
================================

// Module: eth_tx_framer
// PURPOSE
// - Transmit-side framer between the MAC client byte stream and the GMII-style PHY byte interface.
// - Per frame it emits, in order: preamble, SFD, client bytes, zero pad up to the minimum length,
//   then the 4-byte FCS, followed by the inter-frame gap.
// - Computes the CRC-32 on the fly over client and pad bytes; produces no FCS on abort.
// PARAMETERS
// - PAD_EN   1     1: zero-pad payload to MIN_LEN bytes; 0: no padding
// - MIN_LEN  60    minimum bytes before FCS (DA..pad), used when PAD_EN=1
// - MAX_LEN  1514  maximum client bytes per frame; more is an oversize error
// - IFG_LEN  12    idle cycles (tx_en=0) after every frame or abort
// PORTS
// - clk         in   1   clock
// - rst         in   1   reset, synchronous, active-high
// - s_data      in   8   client byte
// - s_valid     in   1   s_data valid
// - s_last      in   1   s_data is the last client byte of the frame
// - s_ready     out  1   framer accepts s_data this cycle
// - txd         out  8   PHY byte, registered
// - tx_en       out  1   PHY transmit enable, registered
// - tx_er       out  1   PHY error flag, registered
// - busy        out  1   high in every state except IDLE
// - frame_done  out  1   one-cycle pulse on the cycle the last FCS byte is on txd
// - err_underrun out 1   one-cycle pulse: s_valid low in DATA
// - err_oversize out 1   one-cycle pulse: MAX_LEN bytes accepted without s_last
// BEHAVIOUR
// - Reset state: IDLE, CRC=32'hFFFFFFFF, counters 0.
//   Outputs at reset: txd=0, tx_en=0, tx_er=0, s_ready=0, busy=0, pulses 0.
// - FSM: IDLE -> PREAMBLE(7) -> SFD -> DATA -> [PAD] -> FCS(4) -> IFG(IFG_LEN) -> IDLE.
// - IDLE -> PREAMBLE on the first cycle s_valid=1; that byte is not consumed.
// - Edge timing: the edge leaving IDLE loads txd=0x55, tx_en=1; 7 edges load 0x55; the next loads 0xD5.
// - DATA: s_ready=1 combinationally only in DATA; each accept loads txd<=s_data and updates the CRC.
//   The accept also increments a 11-bit byte count.
// - DATA exit on accept with s_last=1:
//   - PAD when PAD_EN and count+1 < MIN_LEN;
//   - otherwise FCS.
// - PAD: txd<=0x00, CRC updated, until count==MIN_LEN, then FCS.
// - FCS: fcs=~crc (reflected CRC, poly 0xEDB88320), sent LSB byte first: fcs[7:0],[15:8],[23:16],[31:24].
//   frame_done pulses with the registered 4th FCS byte.
// - Underrun (DATA, s_valid=0): txd<=0, tx_en<=1, tx_er<=1 for one byte, err_underrun pulse.
//   Then IFG; no FCS; the client drops the remaining bytes itself while s_ready=0.
// - Oversize: the accept that makes count==MAX_LEN with s_last=0 is handled like an underrun on the next byte.
//   err_oversize pulses instead of err_underrun.
// - IFG: tx_en=0, txd=0, count IFG_LEN cycles; s_valid is ignored; a frame may start on the cycle after.
// - s_last with count==MAX_LEN exactly: legal frame, no error.
// - A 1-byte frame is legal (padded when PAD_EN; FCS-only tail when PAD_EN=0).
// - rst mid-frame: next edge forces the reset state. tx_en drops immediately; no FCS or tx_er is emitted.
// - CRC reinitialised to 32'hFFFFFFFF on the IDLE->PREAMBLE edge; byte count cleared at the same time.
// STRUCTURE
// - Shared package global (existing): datalen=8, crc_len=32, crc_poly.
//   Add PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3.
//   Add the tx_state_e enum {IDLE,PREAMBLE,SFD,DATA,PAD,FCS,IFG}.
// - One sub-module: eth_crc32_byte.
//   Combinational next = f(crc, byte), LSB-first reflected form, one byte per cycle.
//   Instantiated once; its enable is (accept | PAD).
// TESTING
// - PAD_EN=0, client "123456789" (0x31..0x39):
//   - txd = 7x55, D5, 31..39, then 26 39 F4 CB;
//   - frame_done on the CB cycle; tx_en high for exactly 21 cycles.
// - PAD_EN=1, 14-byte frame: 46 zero pad bytes follow; the CRC over the 60 bytes + FCS gives a running register of 0xDEBB20E3.
// - Back-to-back frames with s_valid held high: exactly IFG_LEN=12 cycles of tx_en=0 between the last FCS byte and the next 0x55.
// - Underrun: s_valid low after 20 DATA bytes:
//   - one byte with txd=00, tx_er=1, err_underrun=1;
//   - then tx_en=0 for 12 cycles; no FCS.
// - Oversize: 1515 bytes without s_last -> err_oversize after byte 1514, tx_er=1 on byte 1515.
//   A frame of exactly 1514 bytes with s_last is error-free.
// - rst asserted during FCS byte 2: next cycle tx_en=0, busy=0, s_ready=0.
//   The next frame's FCS is still correct (CRC reinitialised).

Source files
------------

// File: rtl/eth_tx_framer_pkg.sv
// Shared constants and types for the Ethernet transmit framer.
// Byte width, CRC-32 parameters, framing bytes and the framer state type.
package eth_tx_framer_pkg;

    localparam int DATALEN = 8;
    localparam int CRC_LEN = 32;
    localparam logic [CRC_LEN-1:0] CRC_POLY = 32'hEDB88320;

    localparam logic [DATALEN-1:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [DATALEN-1:0] SFD_BYTE      = 8'hD5;
    localparam logic [CRC_LEN-1:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [CRC_LEN-1:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    // FCS is the inverted register, sent least significant byte first
    function automatic logic [DATALEN-1:0] fcs_byte(
        input logic [CRC_LEN-1:0] crc,
        input logic [1:0]         idx
    );
        logic [CRC_LEN-1:0] f;
        f = ~crc;
        return f[{idx, 3'b000} +: DATALEN];
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte-per-cycle reflected CRC-32 update (LSB-first).
// Passes the register through unchanged when not enabled.
module eth_crc32_byte
    import eth_tx_framer_pkg::*;
(
    input  logic               i_en,
    input  logic [CRC_LEN-1:0] i_crc,
    input  logic [DATALEN-1:0] i_byte,
    output logic [CRC_LEN-1:0] o_crc
);

    logic [CRC_LEN-1:0] w_c;

    always_comb begin
        w_c = i_crc ^ {{(CRC_LEN - DATALEN){1'b0}}, i_byte};
        for (int k = 0; k < DATALEN; k++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
        end
        o_crc = i_en ? w_c : i_crc;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Transmit framer: preamble, SFD, client bytes, pad, FCS, inter-frame gap.
// All PHY-side outputs are registered; s_ready is decoded from state.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATALEN-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATALEN-1:0] txd,
    output logic               tx_en,
    output logic               tx_er,
    output logic               busy,
    output logic               frame_done,
    output logic               err_underrun,
    output logic               err_oversize
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);

    tx_state_e          r_state;
    logic [CRC_LEN-1:0] r_crc;
    logic [10:0]        r_cnt;
    logic [2:0]         r_pcnt;
    logic [1:0]         r_fcnt;
    logic [7:0]         r_icnt;
    logic               r_ovf;
    logic [DATALEN-1:0] r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               r_frame_done;
    logic               r_err_underrun;
    logic               r_err_oversize;

    logic [CRC_LEN-1:0] w_crc_next;
    logic [DATALEN-1:0] w_crc_byte;
    logic [10:0]        w_cnt_inc;
    logic               w_accept;
    logic               w_crc_en;
    logic               w_pad_needed;

    // Once oversize is flagged the client is stalled until the abort byte
    assign s_ready      = (r_state == DATA) && !r_ovf;
    assign w_accept     = s_ready && s_valid;
    assign w_crc_en     = w_accept || (r_state == PAD);
    assign w_crc_byte   = (r_state == PAD) ? '0 : s_data;
    assign w_cnt_inc    = r_cnt + 11'd1;
    assign w_pad_needed = PAD_EN && (w_cnt_inc < MIN_CNT);

    assign txd          = r_txd;
    assign tx_en        = r_tx_en;
    assign tx_er        = r_tx_er;
    assign busy         = (r_state != IDLE);
    assign frame_done   = r_frame_done;
    assign err_underrun = r_err_underrun;
    assign err_oversize = r_err_oversize;

    eth_crc32_byte u_crc (
        .i_en   (w_crc_en),
        .i_crc  (r_crc),
        .i_byte (w_crc_byte),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_crc          <= CRC_INIT;
            r_cnt          <= '0;
            r_pcnt         <= '0;
            r_fcnt         <= '0;
            r_icnt         <= '0;
            r_ovf          <= 1'b0;
            r_txd          <= '0;
            r_tx_en        <= 1'b0;
            r_tx_er        <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_oversize <= 1'b0;
        end else begin
            r_crc          <= w_crc_next;
            r_tx_er        <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_oversize <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                    if (s_valid) begin
                        r_state <= PREAMBLE;
                        r_txd   <= PREAMBLE_BYTE;
                        r_tx_en <= 1'b1;
                        r_crc   <= CRC_INIT;
                        r_cnt   <= '0;
                        r_pcnt  <= 3'd1;
                        r_ovf   <= 1'b0;
                    end
                end
                PREAMBLE: begin
                    r_txd  <= PREAMBLE_BYTE;
                    r_pcnt <= r_pcnt + 3'd1;
                    if (r_pcnt == 3'd6) begin
                        r_state <= SFD;
                    end
                end
                SFD: begin
                    r_txd   <= SFD_BYTE;
                    r_state <= DATA;
                end
                DATA: begin
                    if (r_ovf || !s_valid) begin
                        r_txd          <= '0;
                        r_tx_er        <= 1'b1;
                        r_err_oversize <= r_ovf;
                        r_err_underrun <= !r_ovf;
                        r_icnt         <= '0;
                        r_state        <= IFG;
                    end else begin
                        r_txd <= s_data;
                        r_cnt <= w_cnt_inc;
                        if (s_last) begin
                            r_fcnt  <= '0;
                            r_state <= w_pad_needed ? PAD : FCS;
                        end else if (w_cnt_inc == MAX_CNT) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    r_txd <= '0;
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= MIN_CNT) begin
                        r_fcnt  <= '0;
                        r_state <= FCS;
                    end
                end
                FCS: begin
                    r_txd  <= fcs_byte(r_crc, r_fcnt);
                    r_fcnt <= r_fcnt + 2'd1;
                    if (r_fcnt == 2'd3) begin
                        r_frame_done <= 1'b1;
                        r_icnt       <= '0;
                        r_state      <= IFG;
                    end
                end
                IFG: begin
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                    r_icnt  <= r_icnt + 8'd1;
                    if (r_icnt == IFG_LAST) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: one unpadded and one padded instance.
// Outputs are logged every falling edge and frames are checked from the log.
module tb_eth_tx_framer;

    localparam int N = 8192;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_s_data = '0;
    logic       a_s_valid = 1'b0;
    logic       a_s_last = 1'b0;
    logic       a_s_ready, a_tx_en, a_tx_er, a_busy;
    logic       a_frame_done, a_err_underrun, a_err_oversize;
    logic [7:0] a_txd;

    logic [7:0] b_s_data = '0;
    logic       b_s_valid = 1'b0;
    logic       b_s_last = 1'b0;
    logic       b_s_ready, b_tx_en, b_tx_er, b_busy;
    logic       b_frame_done, b_err_underrun, b_err_oversize;
    logic [7:0] b_txd;

    eth_tx_framer #(.PAD_EN(1'b0)) u_a (
        .clk          (clk),
        .rst          (rst),
        .s_data       (a_s_data),
        .s_valid      (a_s_valid),
        .s_last       (a_s_last),
        .s_ready      (a_s_ready),
        .txd          (a_txd),
        .tx_en        (a_tx_en),
        .tx_er        (a_tx_er),
        .busy         (a_busy),
        .frame_done   (a_frame_done),
        .err_underrun (a_err_underrun),
        .err_oversize (a_err_oversize)
    );

    eth_tx_framer #(.PAD_EN(1'b1)) u_b (
        .clk          (clk),
        .rst          (rst),
        .s_data       (b_s_data),
        .s_valid      (b_s_valid),
        .s_last       (b_s_last),
        .s_ready      (b_s_ready),
        .txd          (b_txd),
        .tx_en        (b_tx_en),
        .tx_er        (b_tx_er),
        .busy         (b_busy),
        .frame_done   (b_frame_done),
        .err_underrun (b_err_underrun),
        .err_oversize (b_err_oversize)
    );

    logic [7:0] lg_d [2][N];
    logic [4:0] lg_f [2][N];
    int cyc = 0;

    always @(negedge clk) begin
        if (cyc < N) begin
            lg_d[0][cyc] <= a_txd;
            lg_d[1][cyc] <= b_txd;
            lg_f[0][cyc] <= {a_err_oversize, a_err_underrun,
                             a_frame_done, a_tx_er, a_tx_en};
            lg_f[1][cyc] <= {b_err_oversize, b_err_underrun,
                             b_frame_done, b_tx_er, b_tx_en};
        end
        cyc <= cyc + 1;
    end

    int ntests = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bd(input int d, input int i);
        if (i < 0 || i >= N) return 8'h00;
        return lg_d[d][i];
    endfunction

    // kind: 0 tx_en, 1 tx_er, 2 frame_done, 3 err_underrun, 4 err_oversize
    function automatic logic fl(input int d, input int kind, input int i);
        logic [4:0] v;
        if (i < 0 || i >= N) return 1'b0;
        v = lg_f[d][i];
        return v[kind];
    endfunction

    function automatic int cnt_fl(input int d, input int kind,
                                  input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) c += int'(fl(d, kind, i));
        return c;
    endfunction

    function automatic logic [31:0] crcb(input logic [31:0] c,
                                         input logic [7:0] b);
        logic fb;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic logic [31:0] residue(input int d, input int lo,
                                            input int hi);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = lo; i <= hi; i++) c = crcb(c, bd(d, i));
        return c;
    endfunction

    logic [7:0] pl [0:1599];

    task automatic drive(input int d, input logic v, input logic [7:0] b,
                         input logic l);
        if (d == 0) begin
            a_s_valid = v;
            a_s_data  = b;
            a_s_last  = l;
        end else begin
            b_s_valid = v;
            b_s_data  = b;
            b_s_last  = l;
        end
    endtask

    // Called on a falling edge; gives up after stall_lim cycles without an accept
    task automatic send(input int d, input int n, input bit with_last,
                        input bit keep_valid, input int stall_lim,
                        output int acc);
        int  i;
        int  stall;
        logic rdy;
        i = 0;
        stall = 0;
        acc = 0;
        while (i < n && stall < stall_lim) begin
            drive(d, 1'b1, pl[i], with_last && (i == n - 1));
            rdy = (d == 0) ? a_s_ready : b_s_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                i++;
                acc++;
                stall = 0;
            end else begin
                stall++;
            end
        end
        if (!keep_valid) drive(d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic grab(input int d, input int from, output int first,
                        output int last, output int n);
        first = -1;
        last = -1;
        n = 0;
        for (int i = from; i < cyc && i < N; i++) begin
            if (first < 0) begin
                if (fl(d, 0, i)) begin
                    first = i;
                    last = i;
                    n = 1;
                end
            end else if (last == i - 1 && fl(d, 0, i)) begin
                last = i;
                n++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp1 [21] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                              8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34,
                              8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26,
                              8'h39, 8'hF4, 8'hCB};

    initial begin
        int st, f, l, n, f2, l2, n2, acc, bad, sz;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags_a", 32'({a_tx_en, a_tx_er, a_busy, a_s_ready,
            a_frame_done, a_err_underrun, a_err_oversize}), 32'd0);
        chk("rst_txd_a", 32'(a_txd), 32'd0);
        chk("rst_flags_b", 32'({b_tx_en, b_tx_er, b_busy, b_s_ready,
            b_frame_done, b_err_underrun, b_err_oversize}), 32'd0);
        chk("rst_txd_b", 32'(b_txd), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_a", 32'({a_tx_en, a_busy}), 32'd0);

        // "123456789", no padding
        for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
        st = cyc;
        send(0, 9, 1'b1, 1'b0, 40, acc);
        chk("t1_acc", 32'(acc), 32'd9);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("t1_len", 32'(n), 32'd21);
        for (int k = 0; k < 21; k++)
            chk($sformatf("t1_b%0d", k), 32'(bd(0, f + k)), 32'(exp1[k]));
        chk("t1_done_pos", 32'(fl(0, 2, l)), 32'd1);
        chk("t1_done_cnt", 32'(cnt_fl(0, 2, st, cyc - 1)), 32'd1);
        chk("t1_er_cnt", 32'(cnt_fl(0, 1, st, cyc - 1)), 32'd0);

        // Back-to-back with s_valid held high
        st = cyc;
        send(0, 9, 1'b1, 1'b1, 40, acc);
        send(0, 9, 1'b1, 1'b0, 40, acc);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        grab(0, l + 1, f2, l2, n2);
        chk("b2b_len1", 32'(n), 32'd21);
        chk("b2b_gap", 32'(f2 - l - 1), 32'd12);
        chk("b2b_pre2", 32'(bd(0, f2)), 32'h55);
        chk("b2b_len2", 32'(n2), 32'd21);
        chk("b2b_fcs2", 32'(bd(0, l2)), 32'hCB);

        // Underrun after 20 data bytes
        for (int i = 0; i < 20; i++) pl[i] = 8'(i + 1);
        st = cyc;
        send(0, 20, 1'b0, 1'b0, 40, acc);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("ur_len", 32'(n), 32'd29);
        chk("ur_lastdata", 32'(bd(0, l - 1)), 32'h14);
        chk("ur_txd", 32'(bd(0, l)), 32'h00);
        chk("ur_er", 32'(fl(0, 1, l)), 32'd1);
        chk("ur_pulse", 32'(fl(0, 3, l)), 32'd1);
        chk("ur_no_ovs", 32'(fl(0, 4, l)), 32'd0);
        chk("ur_er_cnt", 32'(cnt_fl(0, 1, st, cyc - 1)), 32'd1);
        chk("ur_no_done", 32'(cnt_fl(0, 2, st, cyc - 1)), 32'd0);
        chk("ur_ifg", 32'(cnt_fl(0, 0, l + 1, l + 12)), 32'd0);

        // Oversize: 1515 bytes offered without s_last
        for (int i = 0; i < 1515; i++) pl[i] = 8'(i);
        st = cyc;
        send(0, 1515, 1'b0, 1'b0, 10, acc);
        chk("ov_acc", 32'(acc), 32'd1514);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("ov_len", 32'(n), 32'd1523);
        chk("ov_lastdata", 32'(bd(0, l - 1)), 32'hE9);
        chk("ov_txd", 32'(bd(0, l)), 32'h00);
        chk("ov_er", 32'(fl(0, 1, l)), 32'd1);
        chk("ov_pulse", 32'(fl(0, 4, l)), 32'd1);
        chk("ov_no_ur", 32'(cnt_fl(0, 3, st, cyc - 1)), 32'd0);
        chk("ov_no_done", 32'(cnt_fl(0, 2, st, cyc - 1)), 32'd0);

        // Exactly MAX_LEN bytes with s_last is legal
        st = cyc;
        send(0, 1514, 1'b1, 1'b0, 40, acc);
        chk("mx_acc", 32'(acc), 32'd1514);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("mx_len", 32'(n), 32'd1526);
        chk("mx_done", 32'(fl(0, 2, l)), 32'd1);
        chk("mx_err", 32'(cnt_fl(0, 1, st, cyc - 1) +
            cnt_fl(0, 4, st, cyc - 1)), 32'd0);
        chk("mx_residue", residue(0, f + 8, l), RESIDUE);

        // 1-byte frame without padding: FCS-only tail
        pl[0] = 8'hA5;
        st = cyc;
        send(0, 1, 1'b1, 1'b0, 40, acc);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("one_len", 32'(n), 32'd13);
        chk("one_residue", residue(0, f + 8, l), RESIDUE);

        // Reset while the second FCS byte is on txd
        for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
        send(0, 9, 1'b1, 1'b0, 40, acc);
        repeat (2) @(negedge clk);
        chk("rs_fcs1", 32'({a_tx_en, a_txd}), 32'h139);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_txen", 32'(a_tx_en), 32'd0);
        chk("rs_busy", 32'(a_busy), 32'd0);
        chk("rs_ready", 32'(a_s_ready), 32'd0);
        chk("rs_er_done", 32'({a_tx_er, a_frame_done}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        st = cyc;
        send(0, 9, 1'b1, 1'b0, 40, acc);
        repeat (20) @(negedge clk);
        grab(0, st, f, l, n);
        chk("rs_len", 32'(n), 32'd21);
        chk("rs_fcs", {bd(0, l), bd(0, l - 1), bd(0, l - 2), bd(0, l - 3)},
            32'hCBF43926);

        // Padded instance: 14-byte frame gets 46 pad bytes
        for (int i = 0; i < 14; i++) pl[i] = 8'(i * 17 + 3);
        st = cyc;
        send(1, 14, 1'b1, 1'b0, 40, acc);
        repeat (70) @(negedge clk);
        grab(1, st, f, l, n);
        chk("p14_len", 32'(n), 32'd72);
        bad = 0;
        for (int i = 0; i < 14; i++) if (bd(1, f + 8 + i) !== pl[i]) bad++;
        chk("p14_data", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 22; i < 68; i++) if (bd(1, f + i) !== 8'h00) bad++;
        chk("p14_pad", 32'(bad), 32'd0);
        chk("p14_residue", residue(1, f + 8, l), RESIDUE);
        chk("p14_done", 32'(fl(1, 2, l)), 32'd1);
        chk("p14_er", 32'(cnt_fl(1, 1, st, cyc - 1)), 32'd0);

        // Padding boundary: 1, 59, 60 and 61 client bytes
        for (int t = 0; t < 4; t++) begin
            sz = (t == 0) ? 1 : 58 + t;
            for (int i = 0; i < sz; i++) pl[i] = 8'(8'hC3 ^ i);
            st = cyc;
            send(1, sz, 1'b1, 1'b0, 40, acc);
            repeat (70) @(negedge clk);
            grab(1, st, f, l, n);
            chk($sformatf("pb%0d_len", sz), 32'(n),
                32'(8 + ((sz < 60) ? 60 : sz) + 4));
            chk($sformatf("pb%0d_residue", sz), residue(1, f + 8, l),
                RESIDUE);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
